// File: rtl/duc_upconv.sv
// Digital up-converter: holds each I/Q sample for INTERP clocks, mixes it with an NCO and rounds/saturates to a 12-bit DAC word.
// Optional build macro DUC_DITHER_EN replaces the rounding constant with LFSR dither.
module duc_upconv #(
    parameter int INTERP  = 8,
    parameter int PHASE_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [15:0]        in_i,
    input  logic [15:0]        in_q,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic               bypass,
    output logic [11:0]        dac_out,
    output logic               out_valid,
    output logic               underrun
);

    localparam int CNT_W = $clog2(INTERP);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(INTERP - 1);

    // Quarter-wave sine sample k of 256, evaluated at elaboration with a fixed-point Taylor series (scale 2^30).
    function automatic logic signed [15:0] qsin(input int k);
        longint x;
        longint x2;
        longint term;
        longint acc;
        x    = (longint'(k) * 64'sd3373259426) / 512;
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int n = 1; n <= 6; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        return 16'((acc * 32767 + (64'sd1 <<< 29)) >>> 30);
    endfunction

    // Folds a quarter-wave read into the full circle; the mirrored read of index 0 is the peak, which the table lacks.
    function automatic logic signed [15:0] fold(input logic [9:0] p,
                                                input logic signed [15:0] direct,
                                                input logic signed [15:0] mirror);
        logic signed [15:0] mag;
        if (!p[8])
            mag = direct;
        else if (p[7:0] == 8'd0)
            mag = 16'sd32767;
        else
            mag = mirror;
        return p[9] ? -mag : mag;
    endfunction

    logic signed [15:0] qrom [256];
    for (genvar k = 0; k < 256; k++) begin : g_rom
        localparam logic signed [15:0] VAL = qsin(k);
        assign qrom[k] = VAL;
    end

    logic [CNT_W-1:0]   slot_cnt;
    logic [PHASE_W-1:0] phase_acc;
    logic signed [15:0] hold_i, hold_q;
    logic               hold_byp;
    logic signed [15:0] sin_r, cos_r, i1, q1;
    logic               byp1, byp2;
    logic signed [31:0] p_ic, p_qs;
    logic [11:0]        raw2;
    logic [2:0]         valid_sr;

    assign in_ready  = (slot_cnt == LAST_SLOT) && !reset;
    assign underrun  = in_ready && !in_valid;
    assign out_valid = valid_sr[2];

    logic [9:0]         sin_p, cos_p;
    logic signed [15:0] sin_c, cos_c;
    always_comb begin
        sin_p = phase_acc[PHASE_W-1 -: 10];
        cos_p = sin_p + 10'd256;
        sin_c = fold(sin_p, qrom[sin_p[7:0]], qrom[8'd0 - sin_p[7:0]]);
        cos_c = fold(cos_p, qrom[cos_p[7:0]], qrom[8'd0 - cos_p[7:0]]);
    end

`ifdef DUC_DITHER_EN
    logic [15:0] lfsr;
    always_ff @(posedge clock) begin
        if (reset)
            lfsr <= 16'hACE1;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    logic signed [32:0] rnd;
    assign rnd = {17'd0, lfsr};
`else
    logic signed [32:0] rnd;
    assign rnd = 33'sd262144;
`endif

    logic signed [32:0] mix_sum;
    logic signed [13:0] mix_q;
    logic [11:0]        mix_sat;
    always_comb begin
        mix_sum = 33'(p_ic) - 33'(p_qs) + rnd;
        mix_q   = 14'(mix_sum >>> 19);
        if (mix_q > 14'sd2047)
            mix_sat = 12'h7FF;
        else if (mix_q < -14'sd2048)
            mix_sat = 12'h800;
        else
            mix_sat = mix_q[11:0];
    end

    // Bypass is latched with the sample at each slot, so the output mode only switches between whole samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_cnt  <= '0;
            phase_acc <= '0;
            hold_i    <= '0;
            hold_q    <= '0;
            hold_byp  <= 1'b0;
            sin_r     <= '0;
            cos_r     <= '0;
            i1        <= '0;
            q1        <= '0;
            byp1      <= 1'b0;
            p_ic      <= '0;
            p_qs      <= '0;
            byp2      <= 1'b0;
            raw2      <= '0;
            dac_out   <= '0;
            valid_sr  <= '0;
        end else begin
            slot_cnt  <= (slot_cnt == LAST_SLOT) ? '0 : slot_cnt + 1'b1;
            phase_acc <= phase_acc + phase_inc;
            if (in_ready) begin
                hold_byp <= bypass;
                if (in_valid) begin
                    hold_i <= in_i;
                    hold_q <= in_q;
                end
            end
            sin_r    <= sin_c;
            cos_r    <= cos_c;
            i1       <= hold_i;
            q1       <= hold_q;
            byp1     <= hold_byp;
            p_ic     <= 32'(i1) * 32'(cos_r);
            p_qs     <= 32'(q1) * 32'(sin_r);
            byp2     <= byp1;
            raw2     <= i1[15:4];
            dac_out  <= byp2 ? raw2 : mix_sat;
            valid_sr <= {valid_sr[1:0], 1'b1};
        end
    end

endmodule

// File: tb/tb_duc_upconv.sv
// Directed bench for duc_upconv: a table of steady-state vectors plus cycle-exact sequences for slots, underrun, reset and NCO rotation.
module tb_duc_upconv;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_i = '0;
    logic [15:0] in_q = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] phase_inc = '0;
    logic        bypass = 1'b0;
    logic [11:0] dac_out;
    logic        out_valid;
    logic        underrun;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    typedef struct {
        logic [15:0] pinc;
        logic [15:0] i;
        logic [15:0] q;
        logic        byp;
        int          exp_dac;
    } vec_t;
    vec_t vecs[15];

    always #5 clock = ~clock;

    duc_upconv #(.INTERP(8), .PHASE_W(16)) dut (
        .clock(clock), .reset(reset), .in_i(in_i), .in_q(in_q),
        .in_valid(in_valid), .in_ready(in_ready), .phase_inc(phase_inc),
        .bypass(bypass), .dac_out(dac_out), .out_valid(out_valid), .underrun(underrun)
    );

    task automatic check(input string name, input int cyc, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int dac_s();
        return int'($signed(dac_out));
    endfunction

    // Holds reset across two rising edges; the next negedge releases it and becomes cycle 0.
    task automatic hold_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic [15:0] pinc, input logic [15:0] i, input logic [15:0] q,
                         input logic byp, input logic vld);
        phase_inc = pinc;
        in_i      = i;
        in_q      = q;
        bypass    = byp;
        in_valid  = vld;
    endtask

    initial begin
        int pat[4];
        int e_dac, r;
        logic e_rdy, e_ov, e_und;

        vecs[0]  = '{16'h0000, 16'h4000, 16'h0000, 1'b0, 1024};
        vecs[1]  = '{16'h0000, 16'h4000, 16'h7FFF, 1'b0, 1024};
        vecs[2]  = '{16'h0000, 16'hC000, 16'h0000, 1'b0, -1024};
        vecs[3]  = '{16'h0000, 16'h7FFF, 16'h0000, 1'b0, 2047};
        vecs[4]  = '{16'h0000, 16'h8000, 16'h0000, 1'b0, -2048};
        vecs[5]  = '{16'h0000, 16'd1000, 16'h0000, 1'b0, 62};
        vecs[6]  = '{16'h0000, 16'd16,   16'h0000, 1'b0, 1};
        vecs[7]  = '{16'h0000, 16'd8,    16'h0000, 1'b0, 0};
        vecs[8]  = '{16'h0000, 16'hFFF8, 16'h0000, 1'b0, 0};
        vecs[9]  = '{16'h0000, 16'hFFF0, 16'h0000, 1'b0, -1};
        vecs[10] = '{16'h0000, 16'h7FF0, 16'h0000, 1'b1, 2047};
        vecs[11] = '{16'h1234, 16'h7FF0, 16'h0000, 1'b1, 2047};
        vecs[12] = '{16'h3000, 16'h8000, 16'h1234, 1'b1, -2048};
        vecs[13] = '{16'h0000, 16'h1234, 16'h0000, 1'b1, 291};
        vecs[14] = '{16'h0000, 16'h0000, 16'h8000, 1'b0, 0};

        // Reset state with a valid sample offered.
        drive(16'h1234, 16'h4000, 16'h4000, 1'b0, 1'b1);
        hold_reset();
        #1;
        check("rst_dac", -1, dac_s(), 0);
        check("rst_out_valid", -1, int'(out_valid), 0);
        check("rst_in_ready", -1, int'(in_ready), 0);
        check("rst_underrun", -1, int'(underrun), 0);

        // Steady-state table at fixed phase 0 or in bypass.
        foreach (vecs[v]) begin
            drive(vecs[v].pinc, vecs[v].i, vecs[v].q, vecs[v].byp, 1'b1);
            hold_reset();
            reset = 1'b0;
            repeat (20) @(negedge clock);
            #1;
            check($sformatf("vec%0d_dac", v), 20, dac_s(), vecs[v].exp_dac);
            check($sformatf("vec%0d_valid", v), 20, int'(out_valid), 1);
        end

        // Slot timing, one missed slot, new sample, then a 1-cycle reset landing on a slot.
        drive(16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b1);
        hold_reset();
        for (int cyc = 0; cyc < 65; cyc++) begin
            if (cyc > 0) @(negedge clock);
            reset    = (cyc == 39);
            in_valid = (cyc != 23);
            in_i     = (cyc < 23) ? 16'h4000 : (cyc == 23) ? 16'h0000 : 16'hC000;
            #1;
            if (cyc < 39) begin
                e_rdy = (cyc % 8 == 7);
                e_und = (cyc == 23);
                e_ov  = (cyc >= 3);
                e_dac = (cyc < 11) ? 0 : (cyc < 35) ? 1024 : -1024;
            end else if (cyc == 39) begin
                e_rdy = 1'b0;
                e_und = 1'b0;
                e_ov  = 1'b1;
                e_dac = -1024;
            end else begin
                r     = cyc - 40;
                e_rdy = (r % 8 == 7);
                e_und = 1'b0;
                e_ov  = (r >= 3);
                e_dac = (r >= 11) ? -1024 : 0;
            end
            check("seq_in_ready", cyc, int'(in_ready), int'(e_rdy));
            check("seq_underrun", cyc, int'(underrun), int'(e_und));
            check("seq_out_valid", cyc, int'(out_valid), int'(e_ov));
            check("seq_dac", cyc, dac_s(), e_dac);
        end

        // Quarter-turn NCO, then phase_inc drops to 0 and the phase freezes where it is.
        pat = '{1024, 0, -1024, 0};
        exp_q.delete();
        for (int c = 11; c < 40; c++)
            exp_q.push_back((c < 29) ? 12'(pat[(c - 3) % 4]) : 12'(-1024));
        drive(16'h4000, 16'h4000, 16'h0000, 1'b0, 1'b1);
        hold_reset();
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0) @(negedge clock);
            reset     = 1'b0;
            phase_inc = (cyc < 26) ? 16'h4000 : 16'h0000;
            #1;
            if (cyc >= 11)
                check("rot_dac", cyc, dac_s(), int'($signed(exp_q.pop_front())));
        end

        // One cycle of 1/8-turn step, then full-scale I and Q saturate the output.
        drive(16'h2000, 16'h8000, 16'h7FFF, 1'b0, 1'b1);
        hold_reset();
        for (int cyc = 0; cyc < 31; cyc++) begin
            if (cyc > 0) @(negedge clock);
            reset     = 1'b0;
            phase_inc = (cyc == 0) ? 16'h2000 : 16'h0000;
            #1;
            check("sat_dac", cyc, dac_s(), (cyc < 11) ? 0 : -2048);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
